ula_multiciclo: RTL

Parametrised, registered successor to the processor's combinational ALU. Performs the same opcode/funct operation set, adds an iterative unsigned multiplier with a full double-width product and an iterative restoring divider with a remainder, and places both behind a valid/ready handshake. It sits between the register-read stage and write-back. The control unit stalls on `in_ready`/`out_valid` instead of assuming a one-cycle ALU.

---
 rtl/ula_pkg.sv | 41 ++++
 rtl/ula_muldiv_iter.sv | 82 ++++++++
 rtl/ula_multiciclo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared encodings for the multi-cycle ALU: opcode/funct values and FSM states.
package ula_pkg;

    // Opcode classes (processor encoding)
    localparam logic [5:0] OP_ARIT  = 6'd0;
    localparam logic [5:0] OP_LOGIC = 6'd1;
    localparam logic [5:0] OP_ADDI  = 6'd2;
    localparam logic [5:0] OP_MOVE  = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_JUMP  = 6'd5;
    localparam logic [5:0] OP_LOAD  = 6'd6;
    localparam logic [5:0] OP_STORE = 6'd7;
    localparam logic [5:0] OP_IN    = 6'd8;
    localparam logic [5:0] OP_OUT   = 6'd9;
    localparam logic [5:0] OP_BEQ   = 6'd10;
    localparam logic [5:0] OP_BNE   = 6'd11;
    localparam logic [5:0] OP_DIFF  = 6'd13;
    localparam logic [5:0] OP_SBT   = 6'd15;
    localparam logic [5:0] OP_SET   = 6'd16;
    localparam logic [5:0] OP_SBTE  = 6'd17;
    localparam logic [5:0] OP_SLTE  = 6'd18;
    localparam logic [5:0] OP_JR    = 6'd19;
    localparam logic [5:0] OP_SUBI  = 6'd20;

    // funct for OP_ARIT
    localparam logic [5:0] F_ADD  = 6'd0;
    localparam logic [5:0] F_SUB  = 6'd1;
    localparam logic [5:0] F_MULT = 6'd2;
    localparam logic [5:0] F_DIV  = 6'd3;
    localparam logic [5:0] F_INC  = 6'd4;
    localparam logic [5:0] F_DEC  = 6'd5;

    // funct for OP_LOGIC
    localparam logic [5:0] F_AND = 6'd0;
    localparam logic [5:0] F_OR  = 6'd1;
    localparam logic [5:0] F_NOT = 6'd2;
    localparam logic [5:0] F_XOR = 6'd3;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} ula_estado_t;

endpackage

// File: rtl/ula_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// double-width {hi,lo} register.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : load operands and begin WIDTH iterations
//   i_modo_div     : 0 = multiply (A*B), 1 = divide (A/B)
//   i_a, i_b       : operands, sampled on i_start
//   o_done_c       : high during the cycle whose edge performs the last step
//   o_lo_c, o_hi_c : value {hi,lo} takes at the next edge (product / quotient,remainder)
module ula_muldiv_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_modo_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_lo_c,
    output logic [WIDTH-1:0] o_hi_c
);

    logic             r_busy;
    logic             r_modo_div;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_op;     // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_soma;
    logic [WIDTH:0]   w_desloc;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // One iteration step; the remainder invariant hi < divisor makes the
    // borrow bit of w_sub an exact "shifted >= divisor" test.
    always_comb begin
        w_soma   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
        w_desloc = {r_hi, r_lo[WIDTH-1]};
        w_sub    = w_desloc - {1'b0, r_op};
        w_ge     = ~w_sub[WIDTH];
        if (r_modo_div) begin
            w_hi_nxt = w_ge ? w_sub[WIDTH-1:0] : w_desloc[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_hi_nxt = w_soma[WIDTH:1];
            w_lo_nxt = {w_soma[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_done_c = r_busy && (r_cnt == '0);
    assign o_lo_c   = w_lo_nxt;
    assign o_hi_c   = w_hi_nxt;

    // Operand load and iteration; counter runs WIDTH-1 down to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy     <= 1'b0;
            r_modo_div <= 1'b0;
            r_cnt      <= '0;
            r_op       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_modo_div <= i_modo_div;
            r_cnt      <= CNT_W'(WIDTH - 1);
            r_op       <= i_modo_div ? i_b : i_a;
            r_hi       <= '0;
            r_lo       <= i_modo_div ? i_a : i_b;
        end else if (r_busy) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == '0) r_busy <= 1'b0;
            else             r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Registered multi-cycle ALU with valid/ready handshake.
//   clock, reset_n       : clock, async active-low reset
//   in_valid / in_ready  : operation handshake (Opcode, funct, Dados_1, Dados_2)
//   out_valid / out_ready: result handshake
//   Resultado            : result / product low / quotient
//   Resto                : product high / remainder, else 0
//   Zero                 : branch/jump taken
//   div_zero             : last DIV had divisor 0
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] Dados_1,
    input  logic [WIDTH-1:0] Dados_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Resultado,
    output logic [WIDTH-1:0] Resto,
    output logic             Zero,
    output logic             div_zero
);

    ula_estado_t      r_estado, w_prox;
    logic             r_in_ready, r_out_valid, r_zero, r_div_zero;
    logic [WIDTH-1:0] r_res, r_resto;

    logic             w_in_ready_d, w_out_valid_d, w_zero_d, w_div_zero_d;
    logic [WIDTH-1:0] w_res_d, w_resto_d;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_zero;
    logic             w_start, w_modo_div, w_iter_done;
    logic [WIDTH-1:0] w_iter_lo, w_iter_hi;

    ula_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_start    (w_start),
        .i_modo_div (w_modo_div),
        .i_a        (Dados_1),
        .i_b        (Dados_2),
        .o_done_c   (w_iter_done),
        .o_lo_c     (w_iter_lo),
        .o_hi_c     (w_iter_hi)
    );

    // Single-cycle operation mux
    always_comb begin
        w_alu_res  = '0;
        w_alu_zero = 1'b0;
        case (Opcode)
            OP_ARIT: begin
                case (funct)
                    F_ADD:   w_alu_res = Dados_1 + Dados_2;
                    F_SUB:   w_alu_res = Dados_1 - Dados_2;
                    F_INC:   w_alu_res = Dados_1 + WIDTH'(1);
                    F_DEC:   w_alu_res = Dados_1 - WIDTH'(1);
                    default: w_alu_res = '0;
                endcase
            end
            OP_LOGIC: begin
                case (funct)
                    F_AND:   w_alu_res = Dados_1 & Dados_2;
                    F_OR:    w_alu_res = Dados_1 | Dados_2;
                    F_NOT:   w_alu_res = ~Dados_1;
                    F_XOR:   w_alu_res = Dados_1 ^ Dados_2;
                    default: w_alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LOAD, OP_STORE, OP_IN: w_alu_res = Dados_1 + Dados_2;
            OP_SUBI:         w_alu_res = Dados_1 - Dados_2;
            OP_MOVE, OP_OUT: w_alu_res = Dados_1;
            OP_JUMP: begin
                w_alu_res  = Dados_2;
                w_alu_zero = 1'b1;
            end
            OP_JR:   w_alu_zero = 1'b1;
            OP_BEQ:  w_alu_zero = (Dados_1 == Dados_2);
            OP_BNE:  w_alu_zero = (Dados_1 != Dados_2);
            OP_SLT:  w_alu_res  = WIDTH'(Dados_1 <  Dados_2);
            OP_DIFF: w_alu_res  = WIDTH'(Dados_1 != Dados_2);
            OP_SBT:  w_alu_res  = WIDTH'(Dados_1 >  Dados_2);
            OP_SET:  w_alu_res  = WIDTH'(Dados_1 == Dados_2);
            OP_SBTE: w_alu_res  = WIDTH'(Dados_1 >= Dados_2);
            OP_SLTE: w_alu_res  = WIDTH'(Dados_1 <= Dados_2);
            default: ;
        endcase
    end

    // Next state and next output register values
    always_comb begin
        w_prox       = r_estado;
        w_start      = 1'b0;
        w_modo_div   = 1'b0;
        w_res_d      = r_res;
        w_resto_d    = r_resto;
        w_zero_d     = r_zero;
        w_div_zero_d = r_div_zero;
        case (r_estado)
            IDLE: begin
                if (in_valid) begin
                    if (Opcode == OP_ARIT && funct == F_MULT) begin
                        w_prox  = MUL;
                        w_start = 1'b1;
                    end else if (Opcode == OP_ARIT && funct == F_DIV) begin
                        if (Dados_2 == '0) begin
                            w_prox       = DONE;
                            w_res_d      = '1;
                            w_resto_d    = Dados_1;
                            w_zero_d     = 1'b0;
                            w_div_zero_d = 1'b1;
                        end else begin
                            w_prox     = DIV;
                            w_start    = 1'b1;
                            w_modo_div = 1'b1;
                        end
                    end else begin
                        w_prox       = DONE;
                        w_res_d      = w_alu_res;
                        w_resto_d    = '0;
                        w_zero_d     = w_alu_zero;
                        w_div_zero_d = 1'b0;
                    end
                end
            end
            MUL, DIV: begin
                if (w_iter_done) begin
                    w_prox       = DONE;
                    w_res_d      = w_iter_lo;
                    w_resto_d    = w_iter_hi;
                    w_zero_d     = 1'b0;
                    w_div_zero_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) w_prox = IDLE;
            end
            default: w_prox = IDLE;
        endcase
        w_in_ready_d  = (w_prox == IDLE);
        w_out_valid_d = (w_prox == DONE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado    <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_res       <= '0;
            r_resto     <= '0;
            r_zero      <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_estado    <= w_prox;
            r_in_ready  <= w_in_ready_d;
            r_out_valid <= w_out_valid_d;
            r_res       <= w_res_d;
            r_resto     <= w_resto_d;
            r_zero      <= w_zero_d;
            r_div_zero  <= w_div_zero_d;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Resultado = r_res;
    assign Resto     = r_resto;
    assign Zero      = r_zero;
    assign div_zero  = r_div_zero;

endmodule
